// File: rtl/phase_a_loader_pkg.sv
// phase_a_loader shared definitions
// Operand geometry, word counter width and FSM states
package phase_a_loader_pkg;

  localparam int SIZE  = 3072;
  localparam int RADIX = 54;
  localparam int W     = 64;
  localparam int N     = SIZE / W;
  localparam int CW    = $clog2(N) + 1;

  typedef enum logic [2:0] {
    LOAD_MP,
    LOAD_M,
    LOAD_A,
    FIRE,
    WAIT
  } state_t;

endpackage

// File: rtl/phase_a_loader.sv
// phase_a_loader: assembles m_prime, m, a from a word stream,
// derives m_n serially and hands the set to phase_a
module phase_a_loader
  import phase_a_loader_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [W-1:0]      s_data,
  input  logic              s_last,
  input  logic              pa_done,
  output logic [SIZE-1:0]   a_out,
  output logic [SIZE-1:0]   m_out,
  output logic [SIZE+1:0]   m_n_out,
  output logic [RADIX+1:0]  m_prime_out,
  output logic              en,
  output logic              busy,
  output logic              err
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [TW-1:0] LAST_T   = TW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic          c;
  logic          borrow_in;
  logic [W:0]    sum;
  logic          ld;
  logic          err_raw;
  logic          en_raw;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD_MP;
      cnt   <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tcnt  <= tcnt_nx;
    end
  end

  // Next state, framing checks, handshake and status outputs
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tcnt_nx  = '0;
    s_ready  = 1'b0;
    en_raw   = 1'b0;
    busy     = 1'b0;
    err_raw  = 1'b0;
    unique case (state)
      LOAD_MP: begin
        s_ready = 1'b1;
        if (s_valid) begin
          cnt_nx = '0;
          if (s_last) begin
            err_raw = 1'b1;
          end else begin
            state_nx = LOAD_M;
          end
        end
      end
      LOAD_M: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (s_last) begin
            err_raw  = 1'b1;
            state_nx = LOAD_MP;
            cnt_nx   = '0;
          end else if (cnt == LAST_IDX) begin
            state_nx = LOAD_A;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      LOAD_A: begin
        s_ready = 1'b1;
        if (s_valid) begin
          if (cnt == LAST_IDX) begin
            cnt_nx = '0;
            if (s_last) begin
              state_nx = FIRE;
            end else begin
              err_raw  = 1'b1;
              state_nx = LOAD_MP;
            end
          end else if (s_last) begin
            err_raw  = 1'b1;
            state_nx = LOAD_MP;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      FIRE: begin
        en_raw   = 1'b1;
        busy     = 1'b1;
        state_nx = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (pa_done) begin
          state_nx = LOAD_MP;
        end else if (tcnt == LAST_T) begin
          err_raw  = 1'b1;
          state_nx = LOAD_MP;
        end else begin
          tcnt_nx = tcnt + 1'b1;
        end
      end
      default: begin
        state_nx = LOAD_MP;
        cnt_nx   = '0;
      end
    endcase
  end

  // Pulses are suppressed while reset is being sampled
  always_comb begin
    en  = en_raw & ~rst;
    err = err_raw & ~rst;
    ld  = s_valid & s_ready & ~err_raw;
  end

  // Borrow chain: two's complement of m, one word per accepted m word
  always_comb begin
    borrow_in = (cnt == '0) ? 1'b1 : c;
    sum       = {1'b0, ~s_data} + {{W{1'b0}}, borrow_in};
  end

  // Operand registers; a word that breaks framing is not written
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out       <= '0;
      m_out       <= '0;
      m_n_out     <= '0;
      m_prime_out <= '0;
      c           <= 1'b0;
    end else if (ld) begin
      unique case (state)
        LOAD_MP: begin
          m_prime_out <= s_data[RADIX+1:0];
        end
        LOAD_M: begin
          m_out[cnt*W +: W]   <= s_data;
          m_n_out[cnt*W +: W] <= sum[W-1:0];
          c                   <= sum[W];
          if (cnt == LAST_IDX) begin
            m_n_out[SIZE+1:SIZE] <= sum[W] ? 2'b00 : 2'b11;
          end
        end
        LOAD_A: begin
          a_out[cnt*W +: W] <= s_data;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_a_loader.sv
// tb_phase_a_loader: random frames, scoreboard of expected en/err
// events, reference m_n from plain wide subtraction
module tb_phase_a_loader;
  import phase_a_loader_pkg::*;

  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [W-1:0]      s_data = '0;
  logic              s_last = 1'b0;
  logic              pa_done = 1'b0;
  logic [SIZE-1:0]   a_out;
  logic [SIZE-1:0]   m_out;
  logic [SIZE+1:0]   m_n_out;
  logic [RADIX+1:0]  m_prime_out;
  logic              en;
  logic              busy;
  logic              err;

  phase_a_loader #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last),
    .pa_done(pa_done),
    .a_out(a_out), .m_out(m_out),
    .m_n_out(m_n_out), .m_prime_out(m_prime_out),
    .en(en), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit               is_err;
    int               at;
    logic [RADIX+1:0] mp;
    logic [SIZE-1:0]  m;
    logic [SIZE-1:0]  a;
  } ev_t;

  ev_t q[$];
  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [SIZE+1:0] act,
                     input logic [SIZE+1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h (low 64) want %h (low 64) at cycle %0d",
               name, act[63:0], exp[63:0], cyc);
    end
  endtask

  task automatic miss(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event, want none at cycle %0d", name, cyc);
  endtask

  function automatic logic [SIZE-1:0] rnd_wide();
    logic [SIZE-1:0] r;
    for (int i = 0; i < SIZE / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: every en / err the DUT shows must match the next expectation
  always @(negedge clk) begin
    ev_t e;
    logic [SIZE+1:0] mn_ref;
    if (rst) begin
      chk("pulse_in_rst", {en, err}, '0);
    end else begin
      if (en) begin
        if (q.size() == 0) begin
          miss("unexpected_en");
        end else begin
          e = q.pop_front();
          mn_ref = '0 - {2'b00, e.m};
          chk("en_kind", e.is_err, 1'b0);
          chk("en_cycle", cyc, e.at);
          chk("busy_at_en", busy, 1'b1);
          chk("m_prime_out", m_prime_out, e.mp);
          chk("m_out", m_out, e.m);
          chk("a_out", a_out, e.a);
          chk("m_n_out", m_n_out, mn_ref);
          chk("m_n_top", m_n_out[SIZE+1:SIZE], mn_ref[SIZE+1:SIZE]);
        end
      end
      if (err) begin
        if (q.size() == 0) begin
          miss("unexpected_err");
        end else begin
          e = q.pop_front();
          chk("err_kind", e.is_err, 1'b1);
          chk("err_cycle", cyc, e.at);
        end
      end
    end
  end

  task automatic goto(input int x);
    while (cyc < x) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [RADIX+1:0] mp,
                            input logic [SIZE-1:0] m,
                            input logic [SIZE-1:0] a,
                            input int gap_pct,
                            input int bad_at,
                            input bit no_last,
                            input int rst_at,
                            output int en_cyc);
    int w;
    int guard;
    bit done;
    bit bad;
    logic [W-1:0] d;
    ev_t e;
    w = 0;
    guard = 0;
    done = 0;
    en_cyc = -1;
    while (!done) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 4000) begin
        miss("frame_guard");
        break;
      end
      if (w == rst_at) begin
        s_valid = 1'b0;
        s_last = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      if ($urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        s_last = $urandom_range(1);
        s_data = {$urandom, $urandom};
        continue;
      end
      if (w == 0) d = {8'($urandom), mp};
      else if (w <= N) d = m[(w-1)*W +: W];
      else d = a[(w-1-N)*W +: W];
      bad = (w == bad_at) || (w == 2*N && no_last);
      s_valid = 1'b1;
      s_data = d;
      s_last = (w == bad_at) || (w == 2*N && !no_last);
      if (s_ready) begin
        if (bad) begin
          e = '{is_err: 1'b1, at: cyc, mp: '0, m: '0, a: '0};
          q.push_back(e);
          done = 1;
        end else if (w == 2*N) begin
          en_cyc = cyc + 1;
          e = '{is_err: 1'b0, at: en_cyc, mp: mp, m: m, a: a};
          q.push_back(e);
          done = 1;
        end
        w++;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  // d > TIMEOUT withholds pa_done entirely
  task automatic complete(input int en_cyc, input int d);
    ev_t e;
    if (en_cyc < 0) return;
    if (d > TIMEOUT) begin
      e = '{is_err: 1'b1, at: en_cyc + TIMEOUT, mp: '0, m: '0, a: '0};
      q.push_back(e);
      goto(en_cyc + TIMEOUT + 1);
      @(negedge clk);
      chk("ready_after_timeout", s_ready, 1'b1);
      chk("idle_after_timeout", busy, 1'b0);
    end else begin
      goto(en_cyc + d);
      pa_done = 1'b1;
      @(negedge clk);
      chk("busy_at_done", busy, 1'b1);
      @(posedge clk);
      #1;
      pa_done = 1'b0;
      @(negedge clk);
      chk("ready_after_done", s_ready, 1'b1);
      chk("idle_after_done", busy, 1'b0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, a_out, '0);
    chk({tag, "_m"}, m_out, '0);
    chk({tag, "_mn"}, m_n_out, '0);
    chk({tag, "_mp"}, m_prime_out, '0);
    chk({tag, "_flags"}, {en, busy, err}, '0);
    chk({tag, "_ready"}, s_ready, 1'b1);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    int ec;
    logic [SIZE-1:0] big;
    logic [SIZE-1:0] one;
    one = '0;
    one[0] = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    send_frame(56'h3, one, SIZE'(5), 0, -1, 0, -1, ec);
    complete(ec, 7);

    send_frame(56'($urandom), '0, rnd_wide(), 0, -1, 0, -1, ec);
    complete(ec, 3);

    big = '0;
    big[SIZE-1] = 1'b1;
    big[1:0] = 2'b11;
    send_frame(56'($urandom), big, rnd_wide(), 30, -1, 0, -1, ec);
    complete(ec, 20);

    send_frame(56'h5, rnd_wide(), rnd_wide(), 10, 50, 0, -1, ec);
    chk("no_en_bad_last", ec, -1);
    send_frame(56'($urandom), rnd_wide(), rnd_wide(), 10, -1, 0, -1, ec);
    complete(ec, 4);

    send_frame(56'h7, rnd_wide(), rnd_wide(), 0, 0, 0, -1, ec);
    send_frame(56'h9, rnd_wide(), rnd_wide(), 0, -1, 1, -1, ec);
    chk("no_en_missing_last", ec, -1);

    send_frame(56'($urandom), rnd_wide(), rnd_wide(), 0, -1, 0, -1, ec);
    complete(ec, TIMEOUT + 1);
    send_frame(56'($urandom), rnd_wide(), rnd_wide(), 0, -1, 0, -1, ec);
    complete(ec, TIMEOUT);

    @(posedge clk);
    #1;
    pa_done = 1'b1;
    @(posedge clk);
    #1;
    pa_done = 1'b0;
    @(negedge clk);
    chk("idle_pa_done_ignored", {s_ready, busy}, 2'b10);

    send_frame(56'($urandom), rnd_wide(), rnd_wide(), 20, -1, 0, 70, ec);
    @(negedge clk);
    chk_zero("midframe_rst");
    send_frame(56'($urandom), rnd_wide(), rnd_wide(), 20, -1, 0, -1, ec);
    complete(ec, 2);

    for (int i = 0; i < 3; i++) begin
      send_frame(56'($urandom), rnd_wide(), rnd_wide(),
                 $urandom_range(40), -1, 0, -1, ec);
      complete(ec, $urandom_range(TIMEOUT, 1));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("events_left", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
